// File: rtl/md_pkg.sv
// Shared mult/div definitions: op encodings, default latencies, issue-controller states.
// Used by the decoder, the mult/div unit and md_issue_ctrl.
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MSUB  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MFHI  = 4'd9;
  localparam logic [3:0] MD_MFLO  = 4'd10;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } md_state_e;

  function automatic logic md_is_multicycle(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) ||
           (op == MD_DIVU) || (op == MD_MADD)  || (op == MD_MSUB);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_hilo_move(input logic [3:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO) || (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// Loadable 4-bit down-counter tracking remaining mult/div busy cycles; cancel wins over load.
// Counts one per clock while nonzero, no backpressure; zero_o is combinational from the count.
module md_lat_counter (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_value_i,
  input  logic       cancel_i,
  output logic [3:0] cnt_o,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cancel_i) begin
      cnt_d = 4'd0;
    end else if (load_i) begin
      cnt_d = load_value_i;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/md_issue_ctrl.sv
// D/E issue + stall control for the mult/div unit: 1-cycle start pulse, stall is combinational,
// busy scoreboard of 1+LAT cycles; optional md_busy cross-check under MD_BUSY_CHECK_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [3:0] d_md_op,
  input  logic       e_ready,
  input  logic       inter,
  input  logic       md_busy,
  output logic       stall,
  output logic [3:0] e_md_op,
  output logic       e_md_start,
  output logic       mismatch
);

  md_state_e  state_q, state_d;
  logic [3:0] e_md_op_q, e_md_op_d;
  logic       e_md_start_q, e_md_start_d;
  logic       cnt_load, cnt_cancel;
  logic [3:0] cnt_load_value;
  logic [3:0] cnt;
  logic       cnt_zero;
  logic       advance;
  logic       local_busy;

  md_lat_counter u_lat_counter (
    .clk_i        (clk),
    .reset_i      (reset),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_value),
    .cancel_i     (cnt_cancel),
    .cnt_o        (cnt),
    .zero_o       (cnt_zero)
  );

  assign local_busy = (state_q == ST_ISSUE) || !cnt_zero;
  assign stall      = d_valid && (d_md_op != MD_NONE) && local_busy;
  assign advance    = e_ready && !stall && !inter;

  // e_md_op_q still holds the launched op during ISSUE, so it selects the latency.
  assign cnt_load_value = md_is_div(e_md_op_q) ? 4'(DIV_LAT) : 4'(MUL_LAT);

  always_comb begin
    state_d      = state_q;
    e_md_op_d    = e_md_op_q;
    e_md_start_d = 1'b0;
    cnt_load     = 1'b0;
    cnt_cancel   = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        if (inter) begin
          state_d    = ST_IDLE;
          cnt_cancel = 1'b1;
        end else begin
          state_d  = ST_BUSY;
          cnt_load = 1'b1;
        end
      end
      ST_BUSY: begin
        if (cnt <= 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    if (stall || inter) begin
      e_md_op_d = MD_NONE;
    end else if (advance) begin
      if (d_valid && md_is_multicycle(d_md_op) && (state_q == ST_IDLE)) begin
        e_md_op_d    = d_md_op;
        e_md_start_d = 1'b1;
        state_d      = ST_ISSUE;
      end else if (d_valid && md_is_hilo_move(d_md_op)) begin
        e_md_op_d = d_md_op;
      end else begin
        e_md_op_d = MD_NONE;
      end
    end else if (e_md_start_q) begin
      // E held by other hazards: the launched op must not be presented twice.
      e_md_op_d = MD_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      e_md_op_q    <= MD_NONE;
      e_md_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      e_md_op_q    <= e_md_op_d;
      e_md_start_q <= e_md_start_d;
    end
  end

  assign e_md_op    = e_md_op_q;
  assign e_md_start = e_md_start_q;

`ifdef MD_BUSY_CHECK_EN
  logic mismatch_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_q <= 1'b0;
    end else if (local_busy != md_busy) begin
      mismatch_q <= 1'b1;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_md_busy;
  assign unused_md_busy = md_busy;
  assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: per-cycle vector table with a scoreboard queue for the E-stage
// registers, plus hand sequences for stall length, async reset and the busy cross-check.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid;
  logic [3:0] d_md_op;
  logic       e_ready;
  logic       inter;
  logic       md_busy;
  logic       stall;
  logic [3:0] e_md_op;
  logic       e_md_start;
  logic       mismatch;

  int errors = 0;
  int checks = 0;

  md_issue_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_valid    (d_valid),
    .d_md_op    (d_md_op),
    .e_ready    (e_ready),
    .inter      (inter),
    .md_busy    (md_busy),
    .stall      (stall),
    .e_md_op    (e_md_op),
    .e_md_start (e_md_start),
    .mismatch   (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural mult/div unit: busy = start | cycle!=0; aborted when inter hits its E cycle.
  logic       force_busy_lo = 1'b0;
  logic [3:0] ucyc;
  always @(posedge clk or posedge reset) begin
    if (reset) ucyc <= 4'd0;
    else if (e_md_start) ucyc <= inter ? 4'd0 : ((e_md_op == MD_DIV || e_md_op == MD_DIVU) ? 4'd10 : 4'd5);
    else if (ucyc != 4'd0) ucyc <= ucyc - 4'd1;
  end
  assign md_busy = !force_busy_lo && (e_md_start || (ucyc != 4'd0));

  typedef struct {
    logic       dv;
    logic [3:0] op;
    logic       er;
    logic       it;
    logic       stall;
    logic [3:0] eop;
    logic       st;
  } vec_t;

  typedef struct {
    logic [3:0] eop;
    logic       st;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic dv, input logic [3:0] op, input logic er, input logic it,
                              input logic s, input logic [3:0] eop, input logic st);
    vec_t v;
    v.dv = dv; v.op = op; v.er = er; v.it = it; v.stall = s; v.eop = eop; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] op, input logic er, input logic it);
    d_valid = dv; d_md_op = op; e_ready = er; inter = it;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;
    logic exp_mm;

    reset = 1'b1;
    drive(1'b0, MD_NONE, 1'b0, 1'b0);
    #12;
    check("reset_stall", stall, 4'd0);
    check("reset_e_md_op", e_md_op, MD_NONE);
    check("reset_e_md_start", e_md_start, 4'd0);
    check("reset_mismatch", mismatch, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // mult then mflo: 6 stall cycles, mflo enters on the 7th edge
    add(1, MD_MULT, 1, 0, 0, MD_MULT, 1);
    for (int i = 0; i < 6; i++) add(1, MD_MFLO, 1, 0, 1, MD_NONE, 0);
    add(1, MD_MFLO, 1, 0, 0, MD_MFLO, 0);
    add(0, MD_NONE, 1, 0, 0, MD_NONE, 0);
    // mthi while idle, then e_ready low and inter in idle both block an issue
    add(1, MD_MTHI, 1, 0, 0, MD_MTHI, 0);
    add(0, MD_NONE, 1, 0, 0, MD_NONE, 0);
    add(1, MD_MULT, 0, 0, 0, MD_NONE, 0);
    add(1, MD_MULT, 1, 1, 0, MD_NONE, 0);
    // mult cancelled by inter in its E cycle; mfhi follows without stall
    add(1, MD_MULT, 1, 0, 0, MD_MULT, 1);
    add(1, MD_MFHI, 1, 1, 1, MD_NONE, 0);
    add(1, MD_MFHI, 1, 0, 0, MD_MFHI, 0);
    // inter with e_ready low: bubble instead of holding mfhi
    add(1, MD_MFLO, 0, 1, 0, MD_NONE, 0);
    // div then divu: 11 stall cycles, second start pulse
    add(1, MD_DIV, 1, 0, 0, MD_DIV, 1);
    for (int i = 0; i < 11; i++) add(1, MD_DIVU, 1, 0, 1, MD_NONE, 0);
    add(1, MD_DIVU, 1, 0, 0, MD_DIVU, 1);
    // divu busy with inter at cnt=3 (9th stall row): count keeps going
    for (int i = 0; i < 11; i++) add(1, MD_MFLO, 1, (i == 8) ? 1'b1 : 1'b0, 1, MD_NONE, 0);
    add(1, MD_MFLO, 1, 0, 0, MD_MFLO, 0);
    add(0, MD_NONE, 1, 0, 0, MD_NONE, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dv, vecs[i].op, vecs[i].er, vecs[i].it);
      e.eop = vecs[i].eop; e.st = vecs[i].st; e.idx = i;
      sb.push_back(e);
      @(negedge clk);
      check($sformatf("stall[%0d]", i), stall, vecs[i].stall);
      tick();
      e = sb.pop_front();
      check($sformatf("e_md_op[%0d]", e.idx), e_md_op, e.eop);
      check($sformatf("e_md_start[%0d]", e.idx), e_md_start, e.st);
      check($sformatf("mismatch[%0d]", e.idx), mismatch, 4'd0);
    end

    // mthi arriving at cnt=4 after a mult: stalled exactly 4 cycles
    drive(1, MD_MULT, 1, 0); tick();
    drive(0, MD_NONE, 1, 0); tick();
    tick();
    drive(1, MD_MTHI, 1, 0);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      tick();
    end
    check("mthi_stall_cycles", 4'(n), 4'd4);
    tick();
    check("mthi_enters_e", e_md_op, MD_MTHI);
    check("mthi_no_start", e_md_start, 4'd0);

    // async reset at cnt=4 clears outputs before any edge
    drive(0, MD_NONE, 1, 0); tick();
    drive(1, MD_MULT, 1, 0); tick();
    drive(1, MD_MFLO, 1, 0); tick();
    tick();
    #2;
    check("pre_reset_stall", stall, 4'd1);
    reset = 1'b1;
    #1;
    check("async_reset_stall", stall, 4'd0);
    check("async_reset_e_md_op", e_md_op, MD_NONE);
    check("async_reset_e_md_start", e_md_start, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, MD_MULT, 1, 0);
    tick();
    check("issue_after_reset_op", e_md_op, MD_MULT);
    check("issue_after_reset_start", e_md_start, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_in_issue_op", e_md_op, MD_NONE);
    check("reset_in_issue_start", e_md_start, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, MD_MFHI, 1, 0);
    #1;
    check("idle_after_reset_stall", stall, 4'd0);
    tick();
    check("mfhi_after_reset", e_md_op, MD_MFHI);

    // md_busy forced low at cnt=4: sticky mismatch only with the cross-check built in
`ifdef MD_BUSY_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    drive(1, MD_MULT, 1, 0); tick();
    drive(0, MD_NONE, 1, 0); tick();
    tick();
    force_busy_lo = 1'b1;
    tick();
    force_busy_lo = 1'b0;
    check("mismatch_set", mismatch, {3'd0, exp_mm});
    repeat (8) tick();
    check("mismatch_held", mismatch, {3'd0, exp_mm});
    reset = 1'b1;
    #1;
    check("mismatch_reset", mismatch, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side issue and stall controller for the multiply/divide unit. It sits between the D and E stages of the five-stage MIPS pipeline. It launches each mult/div-class operation into the unit with a one-cycle start pulse and tracks the unit's fixed latency in a local scoreboard. It stalls any later HI/LO-touching instruction in D until the unit is free, and withdraws an operation that an interrupt cancels in its E cycle.

## Interface
Parameters:
- MUL_LAT, 5: busy cycles after the E cycle for mult/multu/madd/msub.
- DIV_LAT, 10: busy cycles after the E cycle for div/divu.

Ports:
- clk  in  1  pipeline clock; one clock domain.
- reset  in  1  asynchronous, active-high.
- d_valid  in  1  the D stage holds a valid instruction.
- d_md_op  in  4  md class of the D instruction (md_pkg encoding; MD_NONE if not md).
- e_ready  in  1  D→E advance permitted by other hazard logic.
- inter  in  1  interrupt/exception flush of the current E instruction.
- md_busy  in  1  busy flag returned by the mult/div unit.
- stall  out  1  hold D and insert a bubble into E (combinational).
- e_md_op  out  4  md op presented to the unit in E (registered).
- e_md_start  out  1  one-cycle launch pulse for a multicycle op.
- mismatch  out  1  local scoreboard disagrees with md_busy (only with MD_BUSY_CHECK_EN).

## Operation
- States:
  - IDLE: no op in flight.
  - ISSUE: the E cycle of a multicycle op.
  - BUSY: counting down.
- 4-bit counter cnt, reset 0.
- Stall rule: `stall = d_valid & (d_md_op != MD_NONE) & (state==ISSUE | cnt!=0)`.
- Advance rules (at a clock edge where `e_ready & !stall & !inter`):
  - A multicycle op (MULT, MULTU, MADD, MSUB, DIV, DIVU) in D: e_md_op ← op, e_md_start ← 1, state → ISSUE.
  - MTHI, MTLO, MFHI or MFLO in D: e_md_op ← op, e_md_start ← 0, state stays IDLE. These are single-cycle and need no scoreboard entry.
- Bubble: e_md_op ← MD_NONE and e_md_start ← 0 when `stall | inter`, or when `!e_ready` with a newly loaded op already started. The start pulse never repeats for the same instruction.
- ISSUE → BUSY: cnt ← MUL_LAT or DIV_LAT by op class; e_md_start ← 0.
- BUSY: cnt decrements each cycle. At cnt==1 the next state is IDLE with cnt=0.
- inter while in ISSUE: the op is cancelled. Next state is IDLE, cnt=0, e_md_op=MD_NONE. The unit restores HI/LO itself.
- inter while in BUSY: the op has already committed. Counting continues unchanged.
- A new multicycle op is never accepted while state≠IDLE; the stall rule guarantees this.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, cnt=0.
  - e_md_op=MD_NONE, e_md_start=0, mismatch=0.
  - stall=0, derived from IDLE.
- Busy window is 1+MUL_LAT = 6 cycles for mult-class ops and 1+DIV_LAT = 11 cycles for div-class ops. This matches the unit's `start | cycle!=0` window.
- stall falls in the same cycle that the counter reaches 0. A stalled D instruction enters E at the following edge.
- Reset asserted mid-BUSY: all state clears without waiting for clk.
- inter and e_ready=0 in the same cycle: inter wins and E becomes a bubble.

## Configuration
- MD_BUSY_CHECK_EN defined:
  - Each cycle compare `local_busy = (state==ISSUE)|(cnt!=0)` with md_busy.
  - On any difference, mismatch is set and held until reset.
- MD_BUSY_CHECK_EN undefined: mismatch is tied to 0 and md_busy is unused.

## Structure
- md_pkg (shared with the mult/div unit and the decoder) holds:
  - the 4-bit op encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MSUB, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO;
  - the default latency constants;
  - the state encodings.
- One sub-module, md_lat_counter: a loadable down-counter with load, load_value, cancel and a zero output, instantiated once.

## Test plan
- mult in D, then mflo in D next cycle → e_md_start pulses once; stall is high exactly 6 cycles; mflo enters E on the 7th edge.
- div followed by divu → divu stalled 11 cycles; then a second start pulse; total busy 22 cycles.
- mult, with inter asserted in its E cycle → next cycle state=IDLE, cnt=0, stall=0; a following mfhi issues with no stall.
- div, with inter asserted at cnt=3 → cnt continues 3,2,1,0; stall is held for those 3 cycles.
- mthi while IDLE → no stall, e_md_start=0; mthi at cnt=4 after a mult → stalled 4 cycles. Async reset at cnt=4 → all outputs 0 before the next edge.
- With MD_BUSY_CHECK_EN: force md_busy=0 while cnt=4 → mismatch=1 and stays 1 until reset.
